// File: rtl/dma_2d_pkg.sv
// Shared encodings and AXI constants for the 2D DMA read/write masters.
// Used by the burst calculator and both masters.
package dma_2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B
  } dma_state_e;

  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [31:0] BOUNDARY_4K     = 32'h0000_1000;
  localparam logic [31:0] MAX_BURST_BYTES = 32'd256;

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizing: min(max burst, bytes left in line, distance to 4 KB).
// Purely combinational; shared by the read and write masters.
import dma_2d_pkg::*;

module dma_burst_calc #(
  parameter logic [31:0] MAX_BYTES = MAX_BURST_BYTES
) (
  input  logic [11:0] i_addr_lo,
  input  logic [31:0] i_width,
  input  logic [31:0] i_line_done,
  output logic [31:0] o_bytes,
  output logic [7:0]  o_len
);

  logic [31:0] w_line_rem;
  logic [31:0] w_to_4k;

  assign w_line_rem = i_width - i_line_done;
  assign w_to_4k    = BOUNDARY_4K - {20'd0, i_addr_lo};

  always_comb begin
    o_bytes = MAX_BYTES;
    if (w_line_rem < o_bytes) o_bytes = w_line_rem;
    if (w_to_4k < o_bytes)    o_bytes = w_to_4k;
  end

  assign o_len = 8'((o_bytes >> 2) - 32'd1);

endmodule

// File: rtl/dma_2d_write_master.sv
// AXI4 write master for the 2D DMA: drains the read->write FIFO
// into a cropped rectangle, one outstanding burst at a time.
import dma_2d_pkg::*;

module dma_2d_write_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_BURST_LEN  = 64
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            i_start,
  input  logic [31:0]                     i_dst_addr,
  input  logic [31:0]                     i_img_width,
  input  logic [31:0]                     i_img_height,
  input  logic [31:0]                     i_img_stride,
  output logic                            o_write_done,
  output logic                            o_busy,
  output logic                            o_error,
  input  logic                            i_fifo_empty,
  input  logic [31:0]                     i_fifo_data,
  output logic                            o_fifo_pop,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                      m_axi_awlen,
  output logic [2:0]                      m_axi_awsize,
  output logic [1:0]                      m_axi_awburst,
  output logic                            m_axi_awvalid,
  input  logic                            m_axi_awready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                            m_axi_wlast,
  output logic                            m_axi_wvalid,
  input  logic                            m_axi_wready,
  input  logic [1:0]                      m_axi_bresp,
  input  logic                            m_axi_bvalid,
  output logic                            m_axi_bready
);

  if (C_M_AXI_DATA_WIDTH != 32 || C_M_AXI_ID_WIDTH < 1) begin : g_cfg_check
    $error("dma_2d_write_master: only 32-bit data supported");
  end

  dma_state_e r_state;
  dma_state_e w_next;

  logic [31:0] r_addr;
  logic [31:0] r_line_start;
  logic [31:0] r_width;
  logic [31:0] r_height;
  logic [31:0] r_stride;
  logic [31:0] r_line_done;
  logic [31:0] r_line_cnt;
  logic [31:0] r_bytes;
  logic [7:0]  r_beats;
  logic [7:0]  r_beat_cnt;
  logic        r_done;
  logic        r_error;

  logic [31:0] w_bytes;
  logic [7:0]  w_len;
  logic        w_idle_start;
  logic        w_empty_job;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_b_hs;
  logic        w_line_end;
  logic        w_last_line;

  dma_burst_calc #(
    .MAX_BYTES (32'(C_M_AXI_BURST_LEN * 4))
  ) u_calc (
    .i_addr_lo   (r_addr[11:0]),
    .i_width     (r_width),
    .i_line_done (r_line_done),
    .o_bytes     (w_bytes),
    .o_len       (w_len)
  );

  assign w_idle_start = i_start && (r_state == ST_IDLE);
  assign w_empty_job  = (i_img_width == 32'd0) || (i_img_height == 32'd0);
  assign w_aw_hs      = m_axi_awvalid && m_axi_awready;
  assign w_w_hs       = m_axi_wvalid && m_axi_wready;
  assign w_b_hs       = m_axi_bvalid && m_axi_bready;
  assign w_line_end   = (r_line_done + r_bytes) == r_width;
  assign w_last_line  = (r_line_cnt + 32'd1) == r_height;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_idle_start && !w_empty_job) w_next = ST_AW;
      end
      ST_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) w_next = ST_W;
      end
      ST_W: begin
        m_axi_wvalid = !i_fifo_empty;
        m_axi_wlast  = (r_beat_cnt == r_beats);
        if (m_axi_wvalid && m_axi_wready && m_axi_wlast)
          w_next = ST_B;
      end
      ST_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid)
          w_next = (w_line_end && w_last_line) ? ST_IDLE : ST_AW;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr       <= '0;
      r_line_start <= '0;
      r_width      <= '0;
      r_height     <= '0;
      r_stride     <= '0;
      r_line_done  <= '0;
      r_line_cnt   <= '0;
      r_bytes      <= '0;
      r_beats      <= '0;
      r_beat_cnt   <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else if (w_idle_start) begin
      r_addr       <= i_dst_addr;
      r_line_start <= i_dst_addr;
      r_width      <= i_img_width;
      r_height     <= i_img_height;
      r_stride     <= i_img_stride;
      r_line_done  <= '0;
      r_line_cnt   <= '0;
      r_error      <= 1'b0;
      r_done       <= w_empty_job;
    end else if (w_aw_hs) begin
      r_beats    <= w_len;
      r_bytes    <= w_bytes;
      r_beat_cnt <= '0;
    end else if (w_w_hs) begin
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end else if (w_b_hs) begin
      if (m_axi_bresp != AXI_RESP_OKAY) r_error <= 1'b1;
      // Completed line: jump to next line start rather than advancing
      if (w_line_end) begin
        r_line_start <= r_line_start + r_stride;
        r_addr       <= r_line_start + r_stride;
        r_line_done  <= '0;
        r_line_cnt   <= r_line_cnt + 32'd1;
        if (w_last_line) r_done <= 1'b1;
      end else begin
        r_addr      <= r_addr + r_bytes;
        r_line_done <= r_line_done + r_bytes;
      end
    end
  end

  assign m_axi_awaddr  = r_addr[C_M_AXI_ADDR_WIDTH-1:0];
  assign m_axi_awlen   = w_len;
  assign m_axi_awsize  = AXI_SIZE_4B;
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_wdata   = i_fifo_data;
  assign m_axi_wstrb   = '1;
  assign o_fifo_pop    = m_axi_wvalid && m_axi_wready;
  assign o_write_done  = r_done;
  assign o_error       = r_error;
  assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dma_2d_write_master.sv
// Directed bench for dma_2d_write_master with an AXI slave model
// and an AW scoreboard of expected {addr, len} per burst.
module tb_dma_2d_write_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_dst_addr = '0;
  logic [31:0] i_img_width = '0;
  logic [31:0] i_img_height = '0;
  logic [31:0] i_img_stride = '0;
  logic        o_write_done;
  logic        o_busy;
  logic        o_error;
  logic        i_fifo_empty = 1'b1;
  logic [31:0] i_fifo_data = '0;
  logic        o_fifo_pop;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awvalid;
  logic        m_axi_awready = 1'b0;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;
  logic        m_axi_bvalid = 1'b0;
  logic        m_axi_bready;

  int n_err = 0;
  int n_chk = 0;
  int word = 0;
  int job_pops = 0;
  logic [39:0] aw_q[$];

  always #5 clk = ~clk;

  dma_2d_write_master dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_dst_addr    (i_dst_addr),
    .i_img_width   (i_img_width),
    .i_img_height  (i_img_height),
    .i_img_stride  (i_img_stride),
    .o_write_done  (o_write_done),
    .o_busy        (o_busy),
    .o_error       (o_error),
    .i_fifo_empty  (i_fifo_empty),
    .i_fifo_data   (i_fifo_data),
    .o_fifo_pop    (o_fifo_pop),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awlen   (m_axi_awlen),
    .m_axi_awsize  (m_axi_awsize),
    .m_axi_awburst (m_axi_awburst),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wlast   (m_axi_wlast),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0;
    m_axi_wready  = 1'b0;
    m_axi_bvalid  = 1'b0;
    i_fifo_empty  = 1'b1;
  endtask

  task automatic start_job(input logic [31:0] a, input logic [31:0] w,
                           input logic [31:0] h, input logic [31:0] s);
    @(negedge clk);
    slave_idle();
    i_dst_addr   = a;
    i_img_width  = w;
    i_img_height = h;
    i_img_stride = s;
    i_start      = 1'b1;
    @(negedge clk);
    i_start      = 1'b0;
  endtask

  task automatic run_job(input int max_cyc, input bit tog,
                         input int empty_at, input int empty_len,
                         input int err_burst, input int stop_pops);
    int cyc = 0;
    int beat = 0;
    int cur_len = 0;
    int nb = 0;
    int gap = 0;
    bit aw_open = 1'b0;
    bit b_pend = 1'b0;
    logic [39:0] e;
    job_pops = 0;
    forever begin
      @(negedge clk);
      if (o_write_done) break;
      if (cyc >= max_cyc) begin
        chk("job_done_in_budget", 64'(o_write_done), 64'd1);
        break;
      end
      cyc++;
      m_axi_awready = (cyc % 3) != 0;
      m_axi_wready  = tog ? ((cyc % 2) == 1) : 1'b1;
      if (job_pops == empty_at && gap < empty_len) begin
        i_fifo_empty = 1'b1;
        gap++;
      end else begin
        i_fifo_empty = 1'b0;
      end
      i_fifo_data  = 32'hA500_0000 + 32'(word);
      m_axi_bvalid = b_pend;
      m_axi_bresp  = (nb - 1 == err_burst) ? 2'b10 : 2'b00;
      #1;
      if (i_fifo_empty) chk("wvalid_when_empty", 64'(m_axi_wvalid), 64'd0);
      if (!aw_open) chk("wvalid_before_aw", 64'(m_axi_wvalid), 64'd0);
      if (m_axi_awvalid && m_axi_awready) begin
        e = (aw_q.size() > 0) ? aw_q.pop_front() : '1;
        chk("aw_addr_len", 64'({m_axi_awaddr, m_axi_awlen}), 64'(e));
        chk("aw_4k", 64'(((m_axi_awaddr & 32'hFFF) +
            (32'(m_axi_awlen) + 32'd1) * 32'd4) <= 32'd4096), 64'd1);
        chk("aw_size_burst", 64'({m_axi_awsize, m_axi_awburst}), 64'h9);
        cur_len = int'(m_axi_awlen);
        aw_open = 1'b1;
        beat = 0;
        nb++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        chk("pop", 64'(o_fifo_pop), 64'd1);
        chk("wdata", 64'(m_axi_wdata), 64'(32'hA500_0000 + 32'(word)));
        chk("wlast", 64'(m_axi_wlast), 64'(beat == cur_len));
        word++;
        job_pops++;
        beat++;
        if (m_axi_wlast) begin
          aw_open = 1'b0;
          b_pend  = 1'b1;
        end
      end else begin
        chk("no_pop", 64'(o_fifo_pop), 64'd0);
      end
      if (m_axi_bvalid && m_axi_bready) b_pend = 1'b0;
      if (stop_pops != 0 && job_pops >= stop_pops) break;
    end
    slave_idle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    chk("rst_wvalid", 64'({m_axi_wvalid, m_axi_wlast, o_fifo_pop}), 64'd0);
    chk("rst_bready", 64'(m_axi_bready), 64'd0);
    chk("rst_flags", 64'({o_write_done, o_error, o_busy}), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_flags", 64'({o_write_done, o_error, o_busy}), 64'd0);

    // two lines of 64 B, stride 256
    aw_q.push_back({32'h1000, 8'd15});
    aw_q.push_back({32'h1100, 8'd15});
    start_job(32'h1000, 32'd64, 32'd2, 32'd256);
    chk("t1_busy", 64'(o_busy), 64'd1);
    run_job(2000, 1'b0, -1, 0, -1, 0);
    chk("t1_pops", 64'(job_pops), 64'd32);
    chk("t1_done", 64'({o_write_done, o_busy, o_error}), 64'h4);
    chk("t1_q", 64'(aw_q.size()), 64'd0);

    // 4 KB split
    aw_q.push_back({32'h0F80, 8'd31});
    aw_q.push_back({32'h1000, 8'd63});
    aw_q.push_back({32'h1100, 8'd31});
    start_job(32'h0F80, 32'd512, 32'd1, 32'd0);
    run_job(2000, 1'b0, -1, 0, -1, 0);
    chk("t2_pops", 64'(job_pops), 64'd128);
    chk("t2_done", 64'(o_write_done), 64'd1);
    chk("t2_q", 64'(aw_q.size()), 64'd0);

    // FIFO stall and wready toggling
    aw_q.push_back({32'h2000, 8'd3});
    start_job(32'h2000, 32'd16, 32'd1, 32'd0);
    run_job(2000, 1'b1, 2, 5, -1, 0);
    chk("t3_pops", 64'(job_pops), 64'd4);
    chk("t3_done", 64'(o_write_done), 64'd1);
    chk("t3_q", 64'(aw_q.size()), 64'd0);

    // SLVERR on first of three bursts
    aw_q.push_back({32'h0000, 8'd63});
    aw_q.push_back({32'h0100, 8'd63});
    aw_q.push_back({32'h0200, 8'd63});
    start_job(32'h0000, 32'd768, 32'd1, 32'd0);
    run_job(3000, 1'b0, -1, 0, 0, 0);
    chk("t4_pops", 64'(job_pops), 64'd192);
    chk("t4_err_done", 64'({o_error, o_write_done}), 64'h3);
    chk("t4_q", 64'(aw_q.size()), 64'd0);

    // degenerate sizes
    start_job(32'h0100, 32'd0, 32'd4, 32'd0);
    chk("t5w_flags", 64'({o_write_done, o_busy, o_error}), 64'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5w_awvalid", 64'(m_axi_awvalid), 64'd0);
    end
    start_job(32'h0100, 32'd64, 32'd0, 32'd64);
    chk("t5h_flags", 64'({o_write_done, o_busy, o_error}), 64'h4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5h_awvalid", 64'(m_axi_awvalid), 64'd0);
    end

    // reset during W phase
    aw_q.push_back({32'h3000, 8'd15});
    start_job(32'h3000, 32'd64, 32'd1, 32'd0);
    run_job(2000, 1'b0, -1, 0, -1, 5);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
    chk("t6_state", 64'({o_busy, o_fifo_pop, m_axi_wlast, o_write_done}), 64'd0);
    reset_n = 1'b1;
    aw_q.push_back({32'h5000, 8'd15});
    aw_q.push_back({32'h5100, 8'd15});
    start_job(32'h5000, 32'd64, 32'd2, 32'd256);
    run_job(2000, 1'b0, -1, 0, -1, 0);
    chk("t6_pops", 64'(job_pops), 64'd32);
    chk("t6_done", 64'({o_write_done, o_error}), 64'h2);
    chk("t6_q", 64'(aw_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
